// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer, synchronous flush and an occupancy output.
// out_data always comes from the main register; the skid register only holds
// the beat accepted while downstream was stalled.
module pipe_stage_reg #(
  parameter int unsigned     DW           = 32,
  parameter logic [DW-1:0]   RESET_VAL    = '0,
  parameter bit              SKID_EN      = 1'b1,
  parameter bit              CLR_ON_FLUSH = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   main_q, main_d;
  logic [DW-1:0]   skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [1:0]      occ_q, occ_d;
  logic            accept;
  logic            deliver;

  // Handshake: registered in_ready with the skid buffer, otherwise a
  // combinational "slot free or being freed this cycle" term.
  assign in_ready  = SKID_EN ? in_ready_q : (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign deliver   = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = occ_q;

  // Next-state and datapath steering; flush overrides every other transition.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
      if (CLR_ON_FLUSH) begin
        main_d = RESET_VAL;
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (deliver && accept) begin
            main_d  = in_data;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end else if (accept && SKID_EN) begin
            // Downstream stalled: park the new beat behind the main one.
            skid_d  = in_data;
            state_d = ST_SKID;
          end
        end
        ST_SKID: begin
          if (deliver) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
    unique case (state_d)
      ST_FULL: occ_d = 2'd1;
      ST_SKID: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // State, payload and registered status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: payload registers are reset too, because out_data must read RESET_VAL right after reset.
      state_q     <= ST_EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg. Two instances share all inputs:
// index 1 has the skid buffer, index 0 is single-entry. A queue-based model
// of held beats predicts every output, checked on each falling edge, plus
// literal expectations for the directed scenarios.
module tb_pipe_stage_reg;

  localparam logic [31:0] RV = 32'h0;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              in_valid;
  logic              out_ready;
  logic [31:0]       in_data;
  logic [1:0]        ir;
  logic [1:0]        ov;
  logic [1:0][31:0]  od;
  logic [1:0][1:0]   occ;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: beats currently held by each instance, oldest first, plus the
  // value the main register shows (stale when empty, RV after flush/reset).
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] mm[2];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DW(32), .RESET_VAL(RV), .SKID_EN(1'b1), .CLR_ON_FLUSH(1'b1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .occupancy(occ[1])
  );

  pipe_stage_reg #(.DW(32), .RESET_VAL(RV), .SKID_EN(1'b0), .CLR_ON_FLUSH(1'b1)) dut0 (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .occupancy(occ[0])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int msize(input int i);
    return (i == 1) ? mq1.size() : mq0.size();
  endfunction

  // Capacity 2 with the skid buffer; otherwise one slot that can be freed
  // in the same cycle by a downstream transfer.
  function automatic logic model_ready(input int i);
    if (i == 1) return msize(1) < 2;
    return (msize(0) == 0) || out_ready;
  endfunction

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    mm[0] = RV;
    mm[1] = RV;
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      logic rdy;
      logic deq;
      rdy = model_ready(i);
      deq = (msize(i) > 0) && out_ready;
      if (flush) begin
        if (i == 1) mq1.delete(); else mq0.delete();
        mm[i] = RV;
      end else begin
        if (deq) begin
          if (i == 1) void'(mq1.pop_front()); else void'(mq0.pop_front());
        end
        if (in_valid && rdy) begin
          if (i == 1) mq1.push_back(in_data); else mq0.push_back(in_data);
        end
        if (msize(i) > 0) mm[i] = (i == 1) ? mq1[0] : mq0[0];
      end
    end
  endtask

  // One clock: model follows the edge, inputs may change 2 time units later.
  task automatic step();
    @(posedge clk);
    if (resetn) model_update();
    #2;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(msize(i) > 0));
        check($sformatf("occupancy[%0d]", i), 32'(occ[i]), 32'(msize(i)));
        check($sformatf("in_ready[%0d]", i), 32'(ir[i]), 32'(model_ready(i)));
        check($sformatf("out_data[%0d]", i), od[i], mm[i]);
      end
    end
  end

  initial begin
    resetn    = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    #1;
    // 1: reset with a beat presented
    resetn = 1'b0;
    model_reset();
    #2;
    check("rst out_valid", 32'(ov[1]), 32'd0);
    check("rst out_data", od[1], 32'h0);
    check("rst occupancy", 32'(occ[1]), 32'd0);
    check("rst in_ready", 32'(ir[1]), 32'd1);
    cmp_en = 1'b1;
    step();
    step();
    resetn = 1'b1;
    step();
    check("post-rst out_data", od[1], 32'hDEAD_BEEF);
    check("post-rst out_valid", 32'(ov[1]), 32'd1);

    // 2: full-rate streaming
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_data = 32'(k);
      step();
      check($sformatf("stream data %0d", k), od[1], 32'(k));
      check($sformatf("stream occ %0d", k), 32'(occ[1]), 32'd1);
      check($sformatf("stream in_ready %0d", k), 32'(ir[1]), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream drained", 32'(ov[1]), 32'd0);

    // 3: backpressure fills the skid buffer, then drains in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAAAA_0001;
    step();
    in_data   = 32'hBBBB_0002;
    step();
    check("bp occ", 32'(occ[1]), 32'd2);
    check("bp in_ready", 32'(ir[1]), 32'd0);
    check("bp hold A", od[1], 32'hAAAA_0001);
    in_valid  = 1'b0;
    step();
    check("bp still A", od[1], 32'hAAAA_0001);
    out_ready = 1'b1;
    step();
    check("bp B next", od[1], 32'hBBBB_0002);
    check("bp in_ready back", 32'(ir[1]), 32'd1);
    check("bp occ 1", 32'(occ[1]), 32'd1);
    step();
    check("bp empty", 32'(ov[1]), 32'd0);

    // 4: flush drops two held beats and the one presented with it
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_00A1;
    step();
    in_data   = 32'h0000_00B2;
    step();
    in_data   = 32'h0000_00C3;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("flush out_valid", 32'(ov[1]), 32'd0);
    check("flush occ", 32'(occ[1]), 32'd0);
    check("flush out_data", od[1], RV);
    check("flush in_ready", 32'(ir[1]), 32'd1);
    out_ready = 1'b1;
    step();
    step();
    check("flush nothing left", 32'(ov[1]), 32'd0);

    // 5: single-entry variant has a combinational in_ready
    in_valid = 1'b1;
    in_data  = 32'h0000_0055;
    step();
    in_data   = 32'h0000_0066;
    out_ready = 1'b0;
    #1;
    check("noskid ready low", 32'(ir[0]), 32'd0);
    out_ready = 1'b1;
    #1;
    check("noskid ready high", 32'(ir[0]), 32'd1);
    step();
    check("noskid replaced", od[0], 32'h0000_0066);
    in_valid = 1'b0;
    step();

    // 6: asynchronous reset while two beats are held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1111_1111;
    step();
    in_data   = 32'h2222_2222;
    step();
    check("pre-arst occ", 32'(occ[1]), 32'd2);
    #1;
    resetn = 1'b0;
    model_reset();
    #1;
    check("arst out_valid", 32'(ov[1]), 32'd0);
    check("arst occ", 32'(occ[1]), 32'd0);
    check("arst out_data", od[1], RV);
    check("arst in_ready", 32'(ir[1]), 32'd1);
    step();
    resetn = 1'b1;
    in_valid = 1'b0;
    step();

    // Random traffic against the model: loss, duplication or reordering
    // shows up as an out_data/occupancy difference.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 49) == 0);
      step();
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    step();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
